spi_cmd_sequencer: RTL and testbench
====================================

// Module: spi_cmd_sequencer
// PURPOSE
//  Upstream command front end for the SPI driver (spi_drv).
//  Buffers SPI transactions (bit count + TX word) in a FIFO and launches them one at a time on the driver's start_cmd/spi_drv_rdy handshake.
//  Captures rx_miso at completion and returns it on a valid/ready response port.
//  Sits between the system/CSR logic and spi_drv.
// PARAMETERS
//  SPI_MAXLEN   16    max bits per transfer; must equal the driver's SPI_MAXLEN
//  FIFO_DEPTH   4     command FIFO entries; power of 2, >=2
//  TIMEOUT_CYC  1024  clk cycles allowed per transfer (SPI_SEQ_TIMEOUT_EN only)
// PORTS
//  clk          in   1                      system clock; all logic on posedge
//  sresetn      in   1                      reset, synchronous, active-low
//  cmd_valid    in   1                      command offered
//  cmd_ready    out  1                      FIFO can accept a command (=!full)
//  cmd_nclks    in   $clog2(SPI_MAXLEN)+1   transfer length in bits
//  cmd_data     in   SPI_MAXLEN             TX word, MSB-first over the low cmd_nclks bits
//  rsp_valid    out  1                      response held
//  rsp_ready    in   1                      response consumed
//  rsp_data     out  SPI_MAXLEN             received word, low n bits valid, upper bits zero
//  rsp_err      out  1                      transfer timed out (0 when macro absent)
//  start_cmd    out  1                      one-cycle launch pulse to spi_drv
//  spi_drv_rdy  in   1                      driver idle/ready
//  n_clks       out  $clog2(SPI_MAXLEN)+1   bit count to driver, held stable during transfer
//  tx_data      out  SPI_MAXLEN             TX word to driver, held stable during transfer
//  rx_miso      in   SPI_MAXLEN             driver receive word
//  fifo_level   out  $clog2(FIFO_DEPTH)+1   entries queued
//  busy         out  1                      FSM not in IDLE, or FIFO non-empty
// BEHAVIOUR
//  Reset values:
//   - All outputs 0 except cmd_ready=1.
//   - FIFO empty; FSM in IDLE.
//   - Reset mid-transfer drops queued commands and any pending response; start_cmd=0 next cycle.
//  FIFO:
//   - Push on cmd_valid & cmd_ready.
//   - cmd_ready = (level < FIFO_DEPTH), evaluated on the current level. A pop in the same cycle does not open a slot when full.
//   - Simultaneous push and pop when not full: level unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//  Length rules:
//   - cmd_nclks > SPI_MAXLEN is clamped to SPI_MAXLEN at push.
//   - cmd_nclks == 0 never drives the driver. It goes IDLE->RESP with rsp_data=0, rsp_err=0.
//  FSM (IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, RESP):
//   - IDLE:
//     - If FIFO non-empty, pop the head into the n_clks/tx_data registers and go to LAUNCH.
//     - rsp is guaranteed free in IDLE.
//   - LAUNCH:
//     - When spi_drv_rdy=1, assert start_cmd for exactly 1 cycle and go to WAIT_ACK.
//     - Otherwise hold in LAUNCH with start_cmd=0.
//   - WAIT_ACK: spi_drv_rdy=0 -> WAIT_DONE.
//   - WAIT_DONE:
//     - spi_drv_rdy=1 -> rsp_data <= rx_miso masked to the low n_clks bits, then RESP.
//     - Registered capture: rsp_valid rises the cycle after rdy returns.
//   - RESP:
//     - rsp_valid=1; data and err held stable until rsp_ready.
//     - On handshake go to IDLE. A next queued command launches no earlier than 2 cycles after the handshake.
//  Other rules:
//   - n_clks/tx_data change only on pop; stable from LAUNCH through RESP.
//   - Minimum latency from cmd accept (empty FIFO, driver ready) to start_cmd: 2 cycles.
// CONFIGURATION
//  SPI_SEQ_TIMEOUT_EN defined:
//   - A counter clears on entry to WAIT_ACK and runs through WAIT_DONE.
//   - On reaching TIMEOUT_CYC: rsp_data=0, rsp_err=1, go to RESP. The driver is not reset.
//   - The next LAUNCH still waits for spi_drv_rdy=1.
//  SPI_SEQ_TIMEOUT_EN undefined:
//   - No counter; WAIT states wait indefinitely.
//   - rsp_err tied 0; TIMEOUT_CYC unused.
// TESTING
//  1. Basic launch:
//     - Stimulus: push {nclks=8, data=0x00A5}; driver model returns rx_miso=0xFF3C.
//     - Response: exactly one start_cmd pulse; n_clks=8, tx_data=0x00A5; rsp_data=0x003C, rsp_err=0.
//  2. FIFO full and drain:
//     - Stimulus: driver held busy; push 5 commands at FIFO_DEPTH=4.
//     - Response: 4 accepted, cmd_ready=0 on the 5th. After release, 4 responses return in push order.
//  3. Length edge cases:
//     - nclks=0: rsp_valid with data 0 and no start_cmd.
//     - nclks=20: n_clks=16 on the driver port.
//  4. Response backpressure:
//     - Stimulus: rsp_ready=0 for 10 cycles with 2 commands queued.
//     - Response: rsp_data stable; no second start_cmd until the handshake.
//  5. Timeout (macro on, TIMEOUT_CYC=16):
//     - Stimulus: driver never drops rdy.
//     - Response: rsp_err=1, rsp_data=0; rsp_valid rises 16 cycles after WAIT_ACK entry.
//     - Macro off: no response.
//  6. Reset mid-transfer:
//     - Stimulus: sresetn=0 for 1 cycle in WAIT_DONE with 2 queued.
//     - Response: fifo_level=0, rsp_valid=0, cmd_ready=1; no start_cmd after reset.

Source files
------------

// File: rtl/spi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_sequencer
// Desc     : Command FIFO and launcher for spi_drv; returns masked rx_miso on a
//            valid/ready port. Optional transfer timeout: SPI_SEQ_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module spi_cmd_sequencer #(
  parameter int SPI_MAXLEN  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          sresetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [$clog2(SPI_MAXLEN):0]   cmd_nclks,
  input  logic [SPI_MAXLEN-1:0]         cmd_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [SPI_MAXLEN-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          start_cmd,
  input  logic                          spi_drv_rdy,
  output logic [$clog2(SPI_MAXLEN):0]   n_clks,
  output logic [SPI_MAXLEN-1:0]         tx_data,
  input  logic [SPI_MAXLEN-1:0]         rx_miso,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int NW = $clog2(SPI_MAXLEN) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic [NW-1:0]         r_fifo_n [FIFO_DEPTH];
  logic [SPI_MAXLEN-1:0] r_fifo_d [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic [NW-1:0]         r_n_clks, w_clamped;
  logic [SPI_MAXLEN-1:0] r_tx_data, r_rsp_data, w_mask;
  logic                  r_rsp_err;
  logic                  w_push, w_pop, w_head_zero;
  logic                  w_capture, w_tmo_exit, w_timeout;

  assign cmd_ready   = (r_level < LW'(FIFO_DEPTH));
  assign w_push      = cmd_valid & cmd_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_level != '0);
  assign w_head_zero = (r_fifo_n[r_rd_ptr] == '0);
  assign w_clamped   = (cmd_nclks > NW'(SPI_MAXLEN)) ? NW'(SPI_MAXLEN) : cmd_nclks;

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_n[r_wr_ptr] <= w_clamped;
      r_fifo_d[r_wr_ptr] <= cmd_data;
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] r_tmo_cnt;

  // Counts cycles since WAIT_ACK entry; start_cmd marks that entry.
  always_ff @(posedge clk) begin
    if (!sresetn || start_cmd)
      r_tmo_cnt <= '0;
    else if (r_state == S_WAIT_ACK || r_state == S_WAIT_DONE)
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_timeout = (r_state == S_WAIT_ACK || r_state == S_WAIT_DONE) &&
                     (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  // TIMEOUT_CYC has no effect without the timeout counter.
  assign w_timeout = 1'b0 & (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk) begin
    if (!sresetn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    start_cmd  = 1'b0;
    w_capture  = 1'b0;
    w_tmo_exit = 1'b0;
    case (r_state)
      S_IDLE:      if (w_pop) w_next = w_head_zero ? S_RESP : S_LAUNCH;
      S_LAUNCH:    if (spi_drv_rdy) begin
                     start_cmd = 1'b1;
                     w_next    = S_WAIT_ACK;
                   end
      S_WAIT_ACK:  if (!spi_drv_rdy) w_next = S_WAIT_DONE;
                   else if (w_timeout) begin
                     w_tmo_exit = 1'b1;
                     w_next     = S_RESP;
                   end
      S_WAIT_DONE: if (spi_drv_rdy) begin
                     w_capture = 1'b1;
                     w_next    = S_RESP;
                   end else if (w_timeout) begin
                     w_tmo_exit = 1'b1;
                     w_next     = S_RESP;
                   end
      S_RESP:      if (rsp_ready) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < SPI_MAXLEN; i++) w_mask[i] = (i < int'(r_n_clks));
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      r_n_clks   <= '0;
      r_tx_data  <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_n_clks  <= r_fifo_n[r_rd_ptr];
        r_tx_data <= r_fifo_d[r_rd_ptr];
      end
      if (w_pop && w_head_zero) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b0;
      end else if (w_capture) begin
        r_rsp_data <= rx_miso & w_mask;
        r_rsp_err  <= 1'b0;
      end else if (w_tmo_exit) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end
    end
  end

  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign n_clks     = r_n_clks;
  assign tx_data    = r_tx_data;
  assign fifo_level = r_level;
  assign busy       = (r_state != S_IDLE) || (r_level != '0);

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cmd_sequencer
// Desc     : Scoreboard bench for spi_cmd_sequencer with a behavioural spi_drv.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_cmd_sequencer;

  localparam int SPI_MAXLEN  = 16;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 16;

  logic        clk = 1'b0;
  logic        sresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_nclks = '0;
  logic [15:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        start_cmd;
  logic        spi_drv_rdy;
  logic [4:0]  n_clks;
  logic [15:0] tx_data;
  logic [15:0] rx_miso;
  logic [2:0]  fifo_level;
  logic        busy;

  always #5 clk = ~clk;

  spi_cmd_sequencer #(
    .SPI_MAXLEN (SPI_MAXLEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .sresetn    (sresetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_nclks  (cmd_nclks),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .start_cmd  (start_cmd),
    .spi_drv_rdy(spi_drv_rdy),
    .n_clks     (n_clks),
    .tx_data    (tx_data),
    .rx_miso    (rx_miso),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  int starts = 0;
  logic [16:0] exp_rsp[$];     // {err, data}
  logic [20:0] exp_launch[$];  // {n_clks, tx_data}

  // Behavioural driver: busy for drv_lat+1 cycles after start_cmd.
  logic        drv_busy = 1'b0;
  logic        drv_stall = 1'b0;
  logic        drv_ignore = 1'b0;
  int          drv_lat = 3;
  int          drv_cnt = 0;
  logic [15:0] drv_tx = '0;
  logic [15:0] rx_reg = '0;

  assign spi_drv_rdy = !drv_busy && !drv_stall;
  assign rx_miso     = rx_reg;

  function automatic logic [15:0] rx_of(input logic [15:0] t);
    return ~t ^ 16'h0066;
  endfunction

  always @(posedge clk) begin
    if (start_cmd && !drv_ignore && !drv_busy) begin
      drv_busy <= 1'b1;
      drv_cnt  <= drv_lat;
      drv_tx   <= tx_data;
    end else if (drv_busy) begin
      if (drv_cnt > 0) drv_cnt <= drv_cnt - 1;
      else begin
        drv_busy <= 1'b0;
        rx_reg   <= rx_of(drv_tx);
      end
    end
  end

  logic        prev_start = 1'b0;
  logic [20:0] mon_l;
  logic [16:0] mon_e;

  always @(negedge clk) begin
    if (sresetn && start_cmd) begin
      starts++;
      checks++;
      if (exp_launch.size() == 0) begin
        errors++;
        $display("FAIL launch_unexpected got n_clks=%0d tx_data=%h required no launch", n_clks, tx_data);
      end else begin
        mon_l = exp_launch.pop_front();
        if ({n_clks, tx_data} !== mon_l) begin
          errors++;
          $display("FAIL launch_fields got n_clks=%0d tx_data=%h required n_clks=%0d tx_data=%h",
                   n_clks, tx_data, mon_l[20:16], mon_l[15:0]);
        end
      end
      checks++;
      if (prev_start) begin
        errors++;
        $display("FAIL start_width got 2+ cycles required 1 cycle");
      end
    end
    prev_start = sresetn && start_cmd;
  end

  always @(negedge clk) begin
    if (sresetn && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_rsp.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got err=%0b data=%h required no response", rsp_err, rsp_data);
      end else begin
        mon_e = exp_rsp.pop_front();
        if ({rsp_err, rsp_data} !== mon_e) begin
          errors++;
          $display("FAIL rsp_data got err=%0b data=%h required err=%0b data=%h",
                   rsp_err, rsp_data, mon_e[16], mon_e[15:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 normal response, 1 timeout response, 2 no response expected
  task automatic enqueue(input logic [4:0] n, input logic [15:0] d, input int mode);
    logic [4:0]  ne;
    logic [16:0] m;
    ne = (n > 5'd16) ? 5'd16 : n;
    m  = (17'h1 << ne) - 17'h1;
    if (ne != 0) exp_launch.push_back({ne, d});
    if (mode == 1)      exp_rsp.push_back({1'b1, 16'h0000});
    else if (mode == 0) exp_rsp.push_back((n == 0) ? 17'h0 : {1'b0, rx_of(d) & m[15:0]});
  endtask

  task automatic push_cmd(input logic [4:0] n, input logic [15:0] d, input int mode);
    int g = 0;
    cmd_valid = 1'b1;
    cmd_nclks = n;
    cmd_data  = d;
    while (!cmd_ready && g < 300) begin
      tick();
      g++;
    end
    if (g >= 300) begin
      checks++;
      errors++;
      $display("FAIL push_wait got cmd_ready=0 required cmd_ready=1 within 300 cycles");
    end else begin
      enqueue(n, d, mode);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit);
    int g = 0;
    while (!rsp_valid && g < limit) begin
      tick();
      g++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_wait got rsp_valid=0 required 1 within %0d cycles", limit);
    end
  endtask

  task automatic wait_idle(input int limit);
    int g = 0;
    while ((exp_rsp.size() != 0 || busy) && g < limit) begin
      tick();
      g++;
    end
    checks++;
    if (g >= limit) begin
      errors++;
      $display("FAIL drain got pending=%0d busy=%0b required pending=0 busy=0", exp_rsp.size(), busy);
    end
  endtask

  task automatic apply_reset(input int cycles);
    sresetn   = 1'b0;
    cmd_valid = 1'b0;
    repeat (cycles) tick();
    exp_rsp.delete();
    exp_launch.delete();
    sresetn = 1'b1;
  endtask

  task automatic test_reset();
    sresetn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, start_cmd, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl got rdy/val/err/start/busy=%b required 10000",
               {cmd_ready, rsp_valid, rsp_err, start_cmd, busy});
    end
    checks++;
    if ({fifo_level, n_clks, tx_data, rsp_data} !== '0) begin
      errors++;
      $display("FAIL reset_data got level=%0d n_clks=%0d tx=%h rsp=%h required all 0",
               fifo_level, n_clks, tx_data, rsp_data);
    end
    sresetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int s0 = starts;
    push_cmd(5'd8, 16'h00A5, 0);
    checks++;
    if (start_cmd !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_start got start_cmd=%0b required 0", start_cmd);
    end
    tick();
    checks++;
    if (start_cmd !== 1'b1 || n_clks !== 5'd8 || tx_data !== 16'h00A5) begin
      errors++;
      $display("FAIL basic_launch got start=%0b n_clks=%0d tx=%h required start=1 n_clks=8 tx=00a5",
               start_cmd, n_clks, tx_data);
    end
    wait_rsp(50);
    checks++;
    if (rsp_data !== 16'h003C || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_rsp got data=%h err=%0b required data=003c err=0", rsp_data, rsp_err);
    end
    wait_idle(100);
    checks++;
    if (starts - s0 !== 1) begin
      errors++;
      $display("FAIL basic_start_count got %0d required 1", starts - s0);
    end
  endtask

  task automatic test_fifo_full();
    int s0 = starts;
    drv_stall = 1'b1;
    push_cmd(5'd4, 16'h1111, 0);
    repeat (2) tick();
    checks++;
    if (fifo_level !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_blocker got level=%0d busy=%0b required level=0 busy=1", fifo_level, busy);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_accept%0d got cmd_ready=%0b required 1", i, cmd_ready);
      end
      push_cmd(5'(5 + 3 * i), 16'h0F0F + 16'(i) * 16'h1357, 0);
    end
    checks++;
    if (fifo_level !== 3'd4 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_level got level=%0d cmd_ready=%0b required level=4 cmd_ready=0",
               fifo_level, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_nclks = 5'd9;
    cmd_data  = 16'hDEAD;
    repeat (3) tick();
    cmd_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd4 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_reject got level=%0d cmd_ready=%0b required level=4 cmd_ready=0",
               fifo_level, cmd_ready);
    end
    drv_stall = 1'b0;
    wait_idle(400);
    checks++;
    if (starts - s0 !== 5) begin
      errors++;
      $display("FAIL full_start_count got %0d required 5", starts - s0);
    end
  endtask

  task automatic test_length();
    int s0 = starts;
    push_cmd(5'd0, 16'hBEEF, 0);
    wait_rsp(20);
    checks++;
    if (rsp_data !== 16'h0000 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL len0_rsp got data=%h err=%0b required data=0000 err=0", rsp_data, rsp_err);
    end
    wait_idle(50);
    checks++;
    if (starts !== s0) begin
      errors++;
      $display("FAIL len0_start got %0d starts required 0", starts - s0);
    end
    push_cmd(5'd20, 16'hC3A5, 0);
    tick();
    checks++;
    if (n_clks !== 5'd16) begin
      errors++;
      $display("FAIL len_clamp got n_clks=%0d required 16", n_clks);
    end
    wait_idle(100);
  endtask

  task automatic test_backpressure();
    int s0 = starts;
    logic [15:0] d0;
    logic stable = 1'b1;
    rsp_ready = 1'b0;
    push_cmd(5'd12, 16'h0ABC, 0);
    push_cmd(5'd6, 16'h5A5A, 0);
    wait_rsp(50);
    d0 = rsp_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_data !== d0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_stable got valid=%0b data=%h required valid=1 data=%h", rsp_valid, rsp_data, d0);
    end
    checks++;
    if (starts - s0 !== 1) begin
      errors++;
      $display("FAIL bp_no_launch got %0d starts required 1", starts - s0);
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || start_cmd !== 1'b0) begin
      errors++;
      $display("FAIL bp_after_hs got valid=%0b start=%0b required 0 0", rsp_valid, start_cmd);
    end
    tick();
    checks++;
    if (start_cmd !== 1'b1) begin
      errors++;
      $display("FAIL bp_relaunch got start_cmd=%0b required 1 two cycles after handshake", start_cmd);
    end
    wait_idle(100);
  endtask

  task automatic test_timeout();
    int k = 0;
    drv_ignore = 1'b1;
`ifdef SPI_SEQ_TIMEOUT_EN
    push_cmd(5'd8, 16'h1234, 1);
    while (!start_cmd && k < 10) begin
      tick();
      k++;
    end
    k = 0;
    do begin
      tick();
      k++;
    end while (!rsp_valid && k < 100);
    checks++;
    if (k !== TIMEOUT_CYC + 1) begin
      errors++;
      $display("FAIL tmo_latency got %0d cycles after launch required %0d", k, TIMEOUT_CYC + 1);
    end
    checks++;
    if (rsp_err !== 1'b1 || rsp_data !== 16'h0000) begin
      errors++;
      $display("FAIL tmo_rsp got err=%0b data=%h required err=1 data=0000", rsp_err, rsp_data);
    end
    drv_ignore = 1'b0;
    wait_idle(50);
`else
    push_cmd(5'd8, 16'h1234, 2);
    repeat (40) tick();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL notmo_hang got valid=%0b busy=%0b required valid=0 busy=1", rsp_valid, busy);
    end
    drv_ignore = 1'b0;
    apply_reset(1);
`endif
  endtask

  task automatic test_reset_mid();
    int s1;
    drv_lat = 30;
    for (int i = 0; i < 3; i++) push_cmd(5'd10, 16'h0101 << i, 0);
    repeat (5) tick();
    checks++;
    if (fifo_level !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre got level=%0d busy=%0b required level=2 busy=1", fifo_level, busy);
    end
    apply_reset(1);
    s1 = starts;
    checks++;
    if (fifo_level !== 3'd0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || start_cmd !== 1'b0) begin
      errors++;
      $display("FAIL rmid_post got level=%0d valid=%0b ready=%0b start=%0b required 0 0 1 0",
               fifo_level, rsp_valid, cmd_ready, start_cmd);
    end
    repeat (40) tick();
    checks++;
    if (starts !== s1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_quiet got starts=%0d busy=%0b required starts=0 busy=0", starts - s1, busy);
    end
    drv_lat = 3;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      push_cmd(5'($urandom_range(0, 20)), 16'($urandom), 0);
    wait_idle(500);
    checks++;
    if (exp_launch.size() !== 0) begin
      errors++;
      $display("FAIL b2b_launches got %0d pending launches required 0", exp_launch.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fifo_full();
    test_length();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion required finish within 200000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
